// File: rtl/posit_encoder_pipe_if.sv
// Stream interface for the FIR-to-posit encoder: fir_t input beat and posit_t result,
// each with its own valid/ready pair.
interface posit_encoder_pipe_if #(
    parameter int N        = 16,
    parameter int ES       = 1,
    parameter int EXT_BITS = 8
);
    localparam int TE_BITS   = $clog2(N) + ES + 2;
    localparam int MANT_SIZE = N - ES - 2;

    typedef struct packed {
        logic                        sign;
        logic signed [TE_BITS-1:0]   total_exponent;
        logic        [MANT_SIZE-1:0] mant;
    } fir_t;

    typedef logic [N-1:0] posit_t;

    logic                valid_i;
    logic                ready_o;
    fir_t                fir_i;
    logic [EXT_BITS-1:0] frac_ext_i;
    logic                sticky_i;
    logic                is_zero_i;
    logic                is_nar_i;
    logic                valid_o;
    logic                ready_i;
    posit_t              posit_o;

    modport master (
        output valid_i, fir_i, frac_ext_i, sticky_i, is_zero_i, is_nar_i, ready_i,
        input  ready_o, valid_o, posit_o
    );

    modport slave (
        input  valid_i, fir_i, frac_ext_i, sticky_i, is_zero_i, is_nar_i, ready_i,
        output ready_o, valid_o, posit_o
    );
endinterface

// File: rtl/posit_encoder_pipe.sv
// Two-stage elastic FIR-to-posit encoder: stage 1 packs regime/exponent/fraction and
// extracts guard/sticky, stage 2 rounds to nearest-even, saturates and applies the sign.
module posit_encoder_pipe #(
    parameter int N        = 16,
    parameter int ES       = 1,
    parameter int EXT_BITS = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    posit_encoder_pipe_if.slave   bus
);
    localparam int TE_BITS   = $clog2(N) + ES + 2;
    localparam int MANT_SIZE = N - ES - 2;
    localparam int TAIL_W    = ES + MANT_SIZE - 1 + EXT_BITS;
    localparam int XW        = 2 + TAIL_W + N;
    localparam int SH_W      = $clog2(N);

    localparam logic        [TE_BITS-1:0] SH_MAX = TE_BITS'(N - 1);
    localparam logic signed [TE_BITS-1:0] K_MAX  = TE_BITS'(N - 2);
    localparam logic signed [TE_BITS-1:0] K_MIN  = TE_BITS'(-(N - 2));

    logic                      s1_valid_r;
    logic                      valid_o_r;
    logic [N-1:0]              posit_r;
    logic                      s2_ready_s;
    logic                      ready_s;

    logic signed [TE_BITS-1:0] te_s;
    logic signed [TE_BITS-1:0] k_s;
    logic                      neg_s;
    logic        [TE_BITS-1:0] run_s;
    logic        [SH_W-1:0]    shamt_s;
    logic        [TAIL_W-1:0]  tail_s;
    logic signed [XW-1:0]      str_s;
    logic signed [XW-1:0]      str_sh_s;
    logic        [N-2:0]       body_s;
    logic                      guard_s;
    logic                      sticky_s;
    logic                      sat_max_s;
    logic                      sat_min_s;

    logic [N-2:0]              body_r;
    logic                      guard_r;
    logic                      sticky_r;
    logic                      sign_r;
    logic                      zero_r;
    logic                      nar_r;
    logic                      sat_max_r;
    logic                      sat_min_r;

    logic                      round_s;
    logic [N-1:0]              body_rnd_s;
    logic [N-2:0]              mag_s;
    logic [N-1:0]              posit_s;

    assign s2_ready_s  = !valid_o_r || bus.ready_i;
    assign ready_s     = !s1_valid_r || s2_ready_s;
    assign bus.ready_o = ready_s;
    assign bus.valid_o = valid_o_r;
    assign bus.posit_o = posit_r;

    assign te_s  = $signed(bus.fir_i.total_exponent);
    assign k_s   = te_s >>> ES;
    assign neg_s = k_s[TE_BITS-1];

    generate
        if (ES > 0) begin : g_es_field
            assign tail_s = {te_s[ES-1:0], bus.fir_i.mant[MANT_SIZE-2:0], bus.frac_ext_i};
        end else begin : g_no_es_field
            assign tail_s = {bus.fir_i.mant[MANT_SIZE-2:0], bus.frac_ext_i};
        end
    endgenerate

    // Stage-1 packing: regime run length from k, then one arithmetic shift builds the string.
    always_comb begin
        run_s = neg_s ? ~k_s : k_s;
        if (run_s > SH_MAX) begin
            shamt_s = SH_W'(N - 1);
        end else begin
            shamt_s = run_s[SH_W-1:0];
        end
        // Seed "10" (k>=0, ones fill from the left) or "01" (k<0, zeros fill from the left).
        str_s     = {~neg_s, neg_s, tail_s, {N{1'b0}}};
        str_sh_s  = str_s >>> shamt_s;
        body_s    = str_sh_s[XW-1 -: N-1];
        guard_s   = str_sh_s[XW-N];
        sticky_s  = (|str_sh_s[XW-N-1:0]) | bus.sticky_i;
        sat_max_s = (k_s >= K_MAX);
        sat_min_s = (k_s <  K_MIN);
    end

    // Stage-1 registers: loaded whenever the stage is empty or drains this cycle.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s1_valid_r <= 1'b0;
            body_r     <= {(N-1){1'b0}};
            guard_r    <= 1'b0;
            sticky_r   <= 1'b0;
            sign_r     <= 1'b0;
            zero_r     <= 1'b0;
            nar_r      <= 1'b0;
            sat_max_r  <= 1'b0;
            sat_min_r  <= 1'b0;
        end else if (ready_s) begin
            s1_valid_r <= bus.valid_i;
            if (bus.valid_i) begin
                body_r    <= body_s;
                guard_r   <= guard_s;
                sticky_r  <= sticky_s;
                sign_r    <= bus.fir_i.sign;
                zero_r    <= bus.is_zero_i;
                nar_r     <= bus.is_nar_i;
                sat_max_r <= sat_max_s;
                sat_min_r <= sat_min_s;
            end
        end
    end

    assign round_s    = guard_r & (sticky_r | body_r[0]);
    assign body_rnd_s = {1'b0, body_r} + {{(N-1){1'b0}}, round_s};

    // Stage-2 rounding, saturation and sign; a nonzero value never collapses to 0 or NaR.
    always_comb begin
        mag_s   = {(N-1){1'b0}};
        posit_s = {N{1'b0}};
        if (sat_max_r || body_rnd_s[N-1]) begin
            mag_s = {(N-1){1'b1}};
        end else if (sat_min_r || (body_rnd_s[N-2:0] == {(N-1){1'b0}})) begin
            mag_s = {{(N-2){1'b0}}, 1'b1};
        end else begin
            mag_s = body_rnd_s[N-2:0];
        end
        if (nar_r) begin
            posit_s = {1'b1, {(N-1){1'b0}}};
        end else if (zero_r) begin
            posit_s = {N{1'b0}};
        end else if (sign_r) begin
            posit_s = ~{1'b0, mag_s} + {{(N-1){1'b0}}, 1'b1};
        end else begin
            posit_s = {1'b0, mag_s};
        end
    end

    // Stage-2 output register: holds while the consumer stalls.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_o_r <= 1'b0;
            posit_r   <= {N{1'b0}};
        end else if (s2_ready_s) begin
            valid_o_r <= s1_valid_r;
            if (s1_valid_r) begin
                posit_r <= posit_s;
            end
        end
    end
endmodule

// File: tb/tb_posit_encoder_pipe.sv
// Bench for posit_encoder_pipe (N=16, ES=1): directed test-plan vectors, backpressure,
// mid-stream reset and randomized traffic checked against a bit-string reference model.
module tb_posit_encoder_pipe;
    logic clk = 1'b0;
    logic rst_n = 1'b0;

    posit_encoder_pipe_if #(.N(16), .ES(1), .EXT_BITS(8)) bus ();

    posit_encoder_pipe #(.N(16), .ES(1), .EXT_BITS(8)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    int          vectors     = 0;
    int          miscompares = 0;
    int          acc_cnt     = 0;
    logic [15:0] exp_q[$];
    bit          use_model   = 1'b0;
    logic [15:0] lit_exp     = 16'h0000;
    bit          rdy_seen    = 1'b0;
    bit          prev_stall  = 1'b0;
    logic [15:0] prev_posit  = 16'h0000;

    bit          cur_s, cur_stk, cur_z, cur_n;
    int          cur_te;
    bit [11:0]   cur_frac;
    bit [7:0]    cur_ext;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        vectors++;
        assert (obs === exp_v) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
        end
    endtask

    // Posit value from the rules: regime string, exponent bit, fraction, then round-nearest-even.
    function automatic logic [15:0] model(bit s, int te, bit [11:0] frac, bit [7:0] ext,
                                          bit stk, bit z, bit n);
        bit q[$];
        int k, e, body;
        bit g, st;
        if (n) return 16'h8000;
        if (z) return 16'h0000;
        k = (te >= 0) ? te / 2 : -((1 - te) / 2);
        e = te - 2 * k;
        if (k >= 14) begin
            body = 32'h7FFF;
        end else if (k < -14) begin
            body = 1;
        end else begin
            if (k >= 0) begin
                repeat (k + 1) q.push_back(1'b1);
                q.push_back(1'b0);
            end else begin
                repeat (-k) q.push_back(1'b0);
                q.push_back(1'b1);
            end
            q.push_back(e[0]);
            for (int i = 11; i >= 0; i--) q.push_back(frac[i]);
            for (int i = 7; i >= 0; i--) q.push_back(ext[i]);
            body = 0;
            for (int i = 0; i < 15; i++) body = body * 2 + int'(q[i]);
            g  = q[15];
            st = stk;
            for (int i = 16; i < q.size(); i++) st = st | q[i];
            if (g && (st || (body % 2 == 1))) body++;
            if (body > 32'h7FFF) body = 32'h7FFF;
            if (body == 0) body = 1;
        end
        return s ? 16'(65536 - body) : 16'(body);
    endfunction

    task automatic set_in(input bit s, input int te, input bit [11:0] frac, input bit [7:0] ext,
                          input bit stk, input bit z, input bit n);
        cur_s = s; cur_te = te; cur_frac = frac; cur_ext = ext;
        cur_stk = stk; cur_z = z; cur_n = n;
        bus.fir_i.sign           = s;
        bus.fir_i.total_exponent = 7'(te);
        bus.fir_i.mant           = {1'b1, frac};
        bus.frac_ext_i           = ext;
        bus.sticky_i             = stk;
        bus.is_zero_i            = z;
        bus.is_nar_i             = n;
    endtask

    task automatic rnd_in();
        int te;
        te = ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 32)) - 16
                                         : int'($urandom_range(0, 90)) - 45;
        set_in(1'($urandom), te, 12'($urandom), 8'($urandom), 1'($urandom),
               ($urandom_range(0, 15) == 0), ($urandom_range(0, 15) == 0));
    endtask

    // One clock: sample at negedge (stability, output transfer, input transfer), then step.
    task automatic tick();
        logic [15:0] e;
        @(negedge clk);
        if (prev_stall) begin
            chk("stall_valid_hold", bus.valid_o, 1);
            chk("stall_posit_hold", bus.posit_o, prev_posit);
        end
        prev_stall = bus.valid_o && !bus.ready_i;
        prev_posit = bus.posit_o;
        if (bus.valid_o && bus.ready_i) begin
            vectors++;
            assert (exp_q.size() != 0) else begin
                miscompares++;
                $error("FAIL spurious_beat: observed posit %h with no beat outstanding", bus.posit_o);
            end
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("posit", bus.posit_o, e);
            end
        end
        rdy_seen = bus.ready_o;
        if (bus.valid_i && bus.ready_o) begin
            exp_q.push_back(use_model ? model(cur_s, cur_te, cur_frac, cur_ext, cur_stk, cur_z, cur_n)
                                      : lit_exp);
            acc_cnt++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send_dir(input bit s, input int te, input bit [11:0] frac, input bit [7:0] ext,
                            input bit stk, input bit z, input bit n, input logic [15:0] expv);
        int start;
        int i;
        start     = acc_cnt;
        use_model = 1'b0;
        lit_exp   = expv;
        set_in(s, te, frac, ext, stk, z, n);
        bus.valid_i = 1'b1;
        for (i = 0; i < 10 && acc_cnt == start; i++) tick();
        bus.valid_i = 1'b0;
        chk("send_accept_timeout", acc_cnt - start, 1);
    endtask

    task automatic drain();
        bus.valid_i = 1'b0;
        bus.ready_i = 1'b1;
        for (int i = 0; i < 40 && exp_q.size() > 0; i++) tick();
        chk("drain_remaining", exp_q.size(), 0);
    endtask

    initial begin
        int c;
        int start;
        bus.valid_i = 1'b0;
        bus.ready_i = 1'b1;
        set_in(1'b0, 0, 12'h000, 8'h00, 1'b0, 1'b0, 1'b0);

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid_o", bus.valid_o, 0);
        chk("rst_posit_o", bus.posit_o, 16'h0000);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        tick();
        chk("rst_ready_o", rdy_seen, 1);

        // Two-cycle latency on the basic 1.0 encode
        use_model = 1'b0;
        lit_exp   = 16'h4000;
        set_in(1'b0, 0, 12'h000, 8'h00, 1'b0, 1'b0, 1'b0);
        bus.valid_i = 1'b1;
        tick();
        bus.valid_i = 1'b0;
        chk("lat_cycle1_valid", bus.valid_o, 0);
        tick();
        chk("lat_cycle2_valid", bus.valid_o, 1);
        chk("lat_cycle2_posit", bus.posit_o, 16'h4000);
        drain();

        // Directed test-plan vectors
        send_dir(1'b0,   1, 12'h000, 8'h00, 1'b0, 1'b0, 1'b0, 16'h5000);
        send_dir(1'b0,  -1, 12'h000, 8'h00, 1'b0, 1'b0, 1'b0, 16'h3000);
        send_dir(1'b1,   0, 12'h000, 8'h00, 1'b0, 1'b0, 1'b0, 16'hC000);
        send_dir(1'b0,   0, 12'h000, 8'h80, 1'b0, 1'b0, 1'b0, 16'h4000);
        send_dir(1'b0,   0, 12'h000, 8'h80, 1'b1, 1'b0, 1'b0, 16'h4001);
        send_dir(1'b0,   0, 12'h001, 8'h80, 1'b0, 1'b0, 1'b0, 16'h4002);
        send_dir(1'b0,  40, 12'h000, 8'h00, 1'b0, 1'b0, 1'b0, 16'h7FFF);
        send_dir(1'b0, -40, 12'h000, 8'h00, 1'b0, 1'b0, 1'b0, 16'h0001);
        send_dir(1'b1, -40, 12'h000, 8'h00, 1'b0, 1'b0, 1'b0, 16'hFFFF);
        send_dir(1'b0,   5, 12'h123, 8'h00, 1'b0, 1'b1, 1'b0, 16'h0000);
        send_dir(1'b1,   5, 12'h123, 8'h00, 1'b0, 1'b0, 1'b1, 16'h8000);
        send_dir(1'b0,   5, 12'h123, 8'h00, 1'b0, 1'b1, 1'b1, 16'h8000);
        send_dir(1'b0,  27, 12'hFFF, 8'hFF, 1'b1, 1'b0, 1'b0, 16'h7FFF);
        send_dir(1'b0, -29, 12'h000, 8'h00, 1'b0, 1'b0, 1'b0, 16'h0001);
        drain();

        // Backpressure: 5 back-to-back beats, consumer stalled for the first 3 cycles
        use_model = 1'b1;
        start = acc_cnt;
        c = 0;
        while ((acc_cnt - start) < 5 && c < 30) begin
            rnd_in();
            bus.valid_i = 1'b1;
            bus.ready_i = (c >= 3);
            tick();
            if (c < 2) chk("bp_ready_high", rdy_seen, 1);
            if (c == 2) chk("bp_ready_low", rdy_seen, 0);
            c++;
        end
        bus.valid_i = 1'b0;
        chk("bp_beats_accepted", acc_cnt - start, 5);
        drain();

        // Reset asserted mid-stream discards in-flight beats
        use_model = 1'b1;
        for (int i = 0; i < 3; i++) begin
            rnd_in();
            bus.valid_i = 1'b1;
            tick();
        end
        bus.valid_i = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("midrst_valid_o", bus.valid_o, 0);
        chk("midrst_posit_o", bus.posit_o, 16'h0000);
        exp_q.delete();
        prev_stall = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("post_rst_idle", bus.valid_o, 0);
        end
        send_dir(1'b0, 1, 12'h000, 8'h00, 1'b0, 1'b0, 1'b0, 16'h5000);
        drain();

        // Randomized traffic with random input gaps and output stalls
        use_model = 1'b1;
        for (int i = 0; i < 400; i++) begin
            rnd_in();
            bus.valid_i = ($urandom_range(0, 3) != 0);
            bus.ready_i = ($urandom_range(0, 3) != 0);
            tick();
        end
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
